// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, opcode encodings and the IF/ID queue entry.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
    logic     is_ctl;
  } lc3b_ifid_entry;

  localparam lc3b_word LC3B_NOP = 16'h0000;

  function automatic lc3b_opcode opcode_of(input lc3b_word instr);
    return lc3b_opcode'(instr[15:12]);
  endfunction

endpackage

// File: rtl/ifid_predecode.sv
// Combinational control-flow classifier; a BR only redirects when some nzp bit is set.
module ifid_predecode
  import lc3b_types::*;
(
  input  lc3b_opcode  opcode_i,
  input  logic [2:0]  nzp_i,
  output logic        is_ctl_o
);

  always_comb begin
    is_ctl_o = 1'b0;
    case (opcode_i)
      op_br:                    is_ctl_o = |nzp_i;
      op_jsr, op_jmp, op_trap:  is_ctl_o = 1'b1;
      default:                  is_ctl_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO of {pc, ir} pairs with flush; head presented combinationally.
// Define IFID_PREDECODE_EN to store a per-entry control-flow bit and drive id_is_ctl.
module if_id_queue
  import lc3b_types::*;
#(
  parameter int       DEPTH        = 2,
  parameter lc3b_word BUBBLE_INSTR = LC3B_NOP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [15:0]              fetch_pc,
  input  logic [15:0]              fetch_instr,
  input  logic                     flush,
  input  logic                     id_ready,
  output logic                     flow_IFID,
  output logic                     id_valid,
  output logic [15:0]              id_pc,
  output logic [15:0]              id_ir,
  output logic [$clog2(DEPTH):0]   id_count,
  output logic                     id_is_ctl
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  lc3b_word pc_q [DEPTH];
  lc3b_word ir_q [DEPTH];

  logic push, pop;
  lc3b_ifid_entry head;

  assign flow_IFID = (count_q != CW'(DEPTH));
  assign id_valid  = (count_q != '0);
  assign push      = fetch_valid && flow_IFID && !flush;
  assign pop       = id_valid && id_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally never cleared; only pushes write it, so X on idle fetch buses stays out.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q] <= fetch_pc;
      ir_q[wr_ptr_q] <= fetch_instr;
    end
  end

`ifdef IFID_PREDECODE_EN
  logic ctl_q [DEPTH];
  logic push_is_ctl;

  ifid_predecode u_predecode (
    .opcode_i (opcode_of(fetch_instr)),
    .nzp_i    (fetch_instr[11:9]),
    .is_ctl_o (push_is_ctl)
  );

  always_ff @(posedge clk) begin
    if (push) ctl_q[wr_ptr_q] <= push_is_ctl;
  end

  assign head.is_ctl = ctl_q[rd_ptr_q];
`else
  assign head.is_ctl = 1'b0;
`endif

  assign head.pc = pc_q[rd_ptr_q];
  assign head.ir = ir_q[rd_ptr_q];

  assign id_pc     = id_valid ? head.pc : '0;
  assign id_ir     = id_valid ? head.ir : BUBBLE_INSTR;
  assign id_is_ctl = id_valid && head.is_ctl;
  assign id_count  = count_q;

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between instruction fetch and decode (the IF/ID boundary).
- Captures {PC, instruction} pairs returned by the fetch stage into a small FIFO.
- Presents the oldest pair to decode; drives flow_IFID back to fetch as its accept signal.
- Supports flush on taken branch/jump, so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 2, number of entries; power of two, ≥2.
- BUBBLE_INSTR, 16'h0000, instruction driven on id_ir when the queue is empty (LC-3b BR with nzp=000, i.e. NOP).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- fetch_valid  input  1  fetch has a completed instruction this cycle (cache response, not stalled).
- fetch_pc  input  16  lc3b_word; PC of the instruction being delivered.
- fetch_instr  input  16  lc3b_word; instruction word from instruction memory.
- flush  input  1  discard all buffered entries (redirect from later stage).
- id_ready  input  1  decode consumes the head entry this cycle.
- flow_IFID  output  1  queue can accept a push; fetch advances PC only when high.
- id_valid  output  1  head entry valid.
- id_pc  output  16  lc3b_word; PC of head entry.
- id_ir  output  16  lc3b_word; instruction of head entry, or BUBBLE_INSTR when empty.
- id_count  output  $clog2(DEPTH)+1  current occupancy.
- id_is_ctl  output  1  head entry is a control-flow instruction (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset); no other clock or reset.
- Reset: count=0, rd_ptr=wr_ptr=0, id_valid=0, id_pc=16'h0000, id_ir=BUBBLE_INSTR, id_is_ctl=0, flow_IFID=1. Applies immediately on assertion, including mid-operation; buffered entries are lost.
- flow_IFID = (count != DEPTH). It depends only on registered state; there is no combinational path from id_ready.
- Push: fetch_valid && flow_IFID && !flush. Write the entry at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: id_valid && id_ready && !flush. rd_ptr increments modulo DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: flow_IFID=0, so a push is impossible even if a pop happens that cycle. flow_IFID rises the cycle after the pop.
- Empty: id_valid=0 and id_ir=BUBBLE_INSTR. id_ready is ignored; no underflow and no pointer movement.
- Latency: an entry pushed in cycle N appears at the head no earlier than N+1. There is no fall-through in the same cycle.
- Head outputs are driven combinationally from storage[rd_ptr] and count.
- Flush (synchronous, highest priority after reset): next state is count=0, pointers=0. Any same-cycle push and pop are dropped. flow_IFID is 1 the next cycle.
- Storage contents are not cleared by flush or reset. Only the pointers and count are cleared.
- Counter width is $clog2(DEPTH)+1, so the full state (count==DEPTH) is representable. Pointer wrap is natural modulo DEPTH.
- X on fetch_pc/fetch_instr when fetch_valid=0 must not propagate to outputs.

Optional Feature:
- Macro: IFID_PREDECODE_EN.
- With the macro: each entry stores an is_ctl bit computed at push time. It is 1 when fetch_instr[15:12] ∈ {0000 BR with nzp≠000, 0100 JSR/JSRR, 1100 JMP/RET, 1111 TRAP}. id_is_ctl presents the head's bit and is 0 when empty.
- Without the macro: no per-entry bit is stored and id_is_ctl is tied to 0. The port list is identical in both builds.

Decomposition:
- lc3b_types (shared package):
  - Already has lc3b_word and lc3b_opcode (plus opcode enum constants).
  - Add typedef struct packed { lc3b_word pc; lc3b_word ir; logic is_ctl; } lc3b_ifid_entry.
  - Add localparam lc3b_word LC3B_NOP = 16'h0000.
- One sub-module is natural: ifid_predecode, a combinational opcode-to-is_ctl classifier. It is only instantiated under IFID_PREDECODE_EN and is reusable by decode.

Test Plan:
1. Reset then idle: assert reset asynchronously mid-cycle → id_valid=0, id_ir=16'h0000, id_count=0, flow_IFID=1 immediately.
2. Fill to full with id_ready=0:
   - Pushes: pc=16'h3000 ir=16'h1261, then pc=16'h3002 ir=16'h5020.
   - Required: id_count=2, flow_IFID=0; a third push (pc=16'h3004) is ignored.
   - Head: id_pc=16'h3000, id_ir=16'h1261.
3. Simultaneous push/pop at count=1:
   - Head is 16'h3000; push 16'h3002 with id_ready=1.
   - Required: next cycle id_count=1, id_pc=16'h3002.
4. Flush with a concurrent push:
   - Count=2; assert flush while fetch_valid=1 (pc=16'h3004).
   - Required: next cycle id_count=0, id_valid=0, flow_IFID=1, and 16'h3004 is never presented.
5. Empty pop and wrap:
   - id_ready=1 while empty → no change.
   - Then run 5 push/pop pairs → pointers wrap, and PCs 16'h3000..16'h3008 emerge in order.
6. IFID_PREDECODE_EN:
   - Push 16'h0E02 (BRnzp) and 16'hC1C0 (RET) → id_is_ctl=1 for each.
   - Push 16'h0000 → id_is_ctl=0.
   - Without the macro → id_is_ctl always 0.
